// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared state encoding, holding-register tag layout and default
//            widths for the result dispatcher.
// Revision : 1.0
// ============================================================================
package disp_pkg;

    localparam int C_DW_DEF     = 32;
    localparam int C_CNT_W_DEF  = 16;
    localparam int C_TO_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        SEND    = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic       src;
        logic [7:0] proc_val;
    } disp_tag_t;

endpackage
`default_nettype wire

// File: rtl/dispatch_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_cnt
// Brief    : Per-master word counter with frame-length compare and a one-cycle
//            completion pulse; a length of 0 lets the counter free-run.
// Revision : 1.0
// ============================================================================
module dispatch_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_cmplt
);

    logic [CNT_W-1:0] r_count;
    logic             r_cmplt;
    logic             w_last;

    // Length is sampled live, so a mid-frame change applies at the next compare.
    assign w_last = (i_len != '0) && (r_count == (i_len - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_cmplt <= 1'b0;
        end else begin
            r_cmplt <= i_hs && w_last;
            if (i_hs) begin
                r_count <= w_last ? '0 : (r_count + CNT_W'(1));
            end
        end
    end

    assign o_cmplt = r_cmplt;

endmodule
`default_nettype wire

// File: rtl/result_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : result_dispatcher
// Brief    : Pops tagged results from a FIFO and routes them to one of two
//            masters with valid/ready handshake and per-master frame counting.
//            Optional stall timeout enabled by defining DISPATCH_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module result_dispatcher
    import disp_pkg::*;
#(
    parameter int DW     = C_DW_DEF,
    parameter int CNT_W  = C_CNT_W_DEF,
    parameter int TO_CYC = C_TO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [DW-1:0]    fifo_rdata,
    input  logic             fifo_src,
    input  logic [1:0]       fifo_mode,
    input  logic [7:0]       fifo_proc_val,
    output logic [DW-1:0]    mstr0_data,
    output logic             mstr0_valid,
    input  logic             mstr0_ready,
    output logic [7:0]       mstr0_proc_val,
    input  logic [CNT_W-1:0] mstr0_len,
    output logic             mstr0_cmplt,
    output logic [DW-1:0]    mstr1_data,
    output logic             mstr1_valid,
    input  logic             mstr1_ready,
    output logic [7:0]       mstr1_proc_val,
    input  logic [CNT_W-1:0] mstr1_len,
    output logic             mstr1_cmplt,
    output logic             err_timeout
);

    if (TO_CYC < 1) begin : g_to_cyc_check
        $error("result_dispatcher: TO_CYC must be at least 1");
    end

    disp_state_e r_state;
    logic [DW-1:0] r_data;
    disp_tag_t     r_tag;
    logic          r_armed;

    logic w_send;
    logic w_hs;
    logic w_pop;
    logic w_timeout;

    assign w_send = (r_state == SEND);
    assign w_hs   = w_send && (r_tag.src ? mstr1_ready : mstr0_ready);

    // r_armed keeps the pop low for the first cycle out of reset.
    assign w_pop  = r_armed && !fifo_empty &&
                    ((r_state == IDLE) || w_hs);

    assign fifo_rd_en = w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_tag   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    r_data           <= fifo_rdata;
                    r_tag.src        <= fifo_src;
                    r_tag.proc_val   <= fifo_proc_val;
                    r_state          <= (fifo_mode == 2'd0) ? IDLE : SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        r_state <= w_pop ? RD_WAIT : IDLE;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mstr0_valid    = w_send && !r_tag.src;
    assign mstr1_valid    = w_send &&  r_tag.src;
    assign mstr0_data     = mstr0_valid ? r_data : '0;
    assign mstr1_data     = mstr1_valid ? r_data : '0;
    assign mstr0_proc_val = mstr0_valid ? r_tag.proc_val : 8'h00;
    assign mstr1_proc_val = mstr1_valid ? r_tag.proc_val : 8'h00;

    dispatch_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt0 (
        .clk     (clk),
        .rst     (rst),
        .i_hs    (w_hs && !r_tag.src),
        .i_len   (mstr0_len),
        .o_cmplt (mstr0_cmplt)
    );

    dispatch_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt1 (
        .clk     (clk),
        .rst     (rst),
        .i_hs    (w_hs && r_tag.src),
        .i_len   (mstr1_len),
        .o_cmplt (mstr1_cmplt)
    );

`ifdef DISPATCH_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TO_CYC + 1);

    logic [C_TO_W-1:0] r_stall;
    logic              r_err;

    // Stall count is held at 0 outside SEND, so it starts fresh on every entry.
    assign w_timeout = w_send && !w_hs && (r_stall == C_TO_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_timeout;
            r_stall <= w_send ? (r_stall + C_TO_W'(1)) : '0;
        end
    end

    assign err_timeout = r_err;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
